dram_line_ctrl: RTL

DRAM_LINE_CTRL -- requirements
Module: dram_line_ctrl

---
 rtl/dram_line_ctrl_if.sv | 40 ++++
 rtl/dram_line_ctrl.sv | 104 ++++++++++
 2 files changed

// File: rtl/dram_line_ctrl_if.sv
// Line-transfer bundle between the L1 cache, the line controller and the data RAM.
// The slave view belongs to the controller; the master view belongs to the surrounding system.
interface dram_line_ctrl_if #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] wdata;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DWIDTH-1:0] rdata;
  logic              rdata_valid;
  logic              rdata_last;
  logic              rdata_ready;
  logic [AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_din;
  logic              ram_we;
  logic [DWIDTH-1:0] ram_dout;

  modport slave (
    input  req_valid, req_rw, req_addr,
    input  wdata, wdata_valid, rdata_ready,
    input  ram_dout,
    output req_ready, wdata_ready,
    output rdata, rdata_valid, rdata_last,
    output ram_addr, ram_din, ram_we
  );

  modport master (
    output req_valid, req_rw, req_addr,
    output wdata, wdata_valid, rdata_ready,
    output ram_dout,
    input  req_ready, wdata_ready,
    input  rdata, rdata_valid, rdata_last,
    input  ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/dram_line_ctrl.sv
// Cache-line controller: moves whole lines between the L1 cache and a
// synchronous-read data RAM, one word per beat, in ascending address order.
module dram_line_ctrl #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32,
  parameter int LWORDS = 2
) (
  input logic            clock,
  input logic            reset,
  dram_line_ctrl_if.slave bus
);

  localparam int LB = $clog2(LWORDS);
  localparam int CW = (LB > 0) ? LB : 1;
  localparam logic [AWIDTH-1:0] LMASK = AWIDTH'(LWORDS - 1);
  localparam logic [CW-1:0]     CLAST = CW'(LWORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_DATA
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [AWIDTH-1:0] base;
  logic              rw;
  logic [AWIDTH-1:0] addr;
  logic              last;

  assign addr = base + AWIDTH'(cnt);
  assign last = (cnt == CLAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      base  <= '0;
      rw    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            base  <= bus.req_addr & ~LMASK;
            rw    <= bus.req_rw;
            cnt   <= '0;
            state <= bus.req_rw ? WR : RD_ISSUE;
          end
        end
        WR: begin
          if (bus.wdata_valid) begin
            cnt <= cnt + 1'b1;
            if (last) state <= IDLE;
          end
        end
        RD_ISSUE: state <= RD_DATA;
        RD_DATA: begin
          if (bus.rdata_ready) begin
            if (last) begin
              state <= IDLE;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= RD_ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from state and forced low while reset is held.
  always_comb begin
    bus.req_ready   = 1'b0;
    bus.wdata_ready = 1'b0;
    bus.rdata       = '0;
    bus.rdata_valid = 1'b0;
    bus.rdata_last  = 1'b0;
    bus.ram_addr    = '0;
    bus.ram_din     = '0;
    bus.ram_we      = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: bus.req_ready = 1'b1;
        WR: begin
          bus.wdata_ready = 1'b1;
          bus.ram_addr    = addr;
          bus.ram_din     = bus.wdata;
          bus.ram_we      = bus.wdata_valid & rw;
        end
        RD_ISSUE: bus.ram_addr = addr;
        RD_DATA: begin
          bus.ram_addr    = addr;
          bus.rdata       = bus.ram_dout;
          bus.rdata_valid = 1'b1;
          bus.rdata_last  = last;
        end
        default: bus.req_ready = 1'b0;
      endcase
    end
  end

endmodule
